// File: rtl/imem_loader.sv
// Framed byte-stream loader: header N, then 4N MSB-first bytes, written as words to imem.
// Latency: 4th byte of a word -> imem_we next cycle; 5 cycles/word best case. rx_ready decoded from state.
// Optional trailing checksum byte enabled by macro IMEM_LOADER_CSUM_EN.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CW    = 7
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_ready,
  output logic          imem_we,
  output logic [31:0]   imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [CW-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
`ifdef IMEM_LOADER_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t        state;
  state_t        nxt;
  logic [7:0]    n_reg;
  logic [1:0]    byte_cnt;
  logic [31:0]   word_q;
  logic [CW-1:0] index;
  logic          xfer;
  logic          hdr_bad;
  logic          last_word;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    sum;
`endif

  assign xfer      = rx_valid && rx_ready;
  assign hdr_bad   = (rx_data == 8'd0) || (32'(rx_data) > DEPTH);
  assign last_word = (32'(word_count) + 32'd1) == {24'd0, n_reg};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:  if (start) nxt = S_HDR;
      S_HDR:   if (xfer) nxt = hdr_bad ? S_ERR : S_DATA;
      S_DATA:  if (xfer && byte_cnt == 2'd3) nxt = S_WRITE;
      S_WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          nxt = S_CSUM;
`else
          nxt = S_DONE;
`endif
        end else begin
          nxt = S_DATA;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      S_CSUM:  if (xfer) nxt = (rx_data == sum) ? S_DONE : S_ERR;
`endif
      S_DONE:  if (start) nxt = S_HDR;
      S_ERR:   if (start) nxt = S_HDR;
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_reg      <= 8'd0;
      byte_cnt   <= 2'd0;
      word_q     <= 32'd0;
      index      <= '0;
      word_count <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      sum        <= 8'd0;
`endif
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) word_count <= '0;
        end
        S_HDR: begin
`ifdef IMEM_LOADER_CSUM_EN
          sum <= 8'd0;
`endif
          if (xfer) begin
            n_reg      <= rx_data;
            index      <= '0;
            byte_cnt   <= 2'd0;
            word_count <= '0;
          end
        end
        S_DATA: begin
          if (xfer) begin
            word_q   <= {word_q[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
            sum      <= sum + rx_data;
`endif
          end
        end
        S_WRITE: begin
          index      <= index + CW'(1);
          word_count <= word_count + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // All handshake and status outputs decode the registered state only.
`ifdef IMEM_LOADER_CSUM_EN
  assign rx_ready = (state == S_HDR) || (state == S_DATA) || (state == S_CSUM);
  assign busy     = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE) || (state == S_CSUM);
`else
  assign rx_ready = (state == S_HDR) || (state == S_DATA);
  assign busy     = (state == S_HDR) || (state == S_DATA) || (state == S_WRITE);
`endif
  assign imem_we    = (state == S_WRITE);
  assign imem_addr  = {{(30-CW){1'b0}}, index, 2'b00};
  assign imem_wdata = word_q;
  assign cpu_hold   = (state != S_IDLE) && (state != S_DONE);
  assign done       = (state == S_DONE);
  assign error      = (state == S_ERR);

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream loader that writes a program image into the instruction memory through its write port before the core runs. It sits between a byte source (UART receiver or testbench) and the instruction memory. It assembles 32-bit words from a framed byte stream and writes them to consecutive word-aligned addresses. While loading, it holds the core in reset.

## Interface

Parameters:
- `DEPTH`, 64: instruction memory size in words. The legal word count is 1..DEPTH.
- `CW`, 7: width of `word_count`. Must be at least clog2(DEPTH)+1.

Ports:
- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle pulse that begins a load. Honoured only in IDLE, DONE or ERR.
- `rx_data` in 8: incoming byte.
- `rx_valid` in 1: `rx_data` is valid.
- `rx_ready` out 1: loader accepts a byte. A transfer happens when `rx_valid && rx_ready`.
- `imem_we` out 1: one-cycle instruction-memory write strobe.
- `imem_addr` out 32: byte address, always word-aligned (`4*index`).
- `imem_wdata` out 32: assembled instruction word.
- `cpu_hold` out 1: high while a load is in progress or has failed. The core is kept in reset while it is high.
- `busy` out 1: high in HDR, DATA, WRITE and CSUM.
- `done` out 1: high in DONE.
- `error` out 1: high in ERR.
- `word_count` out CW: number of words written in the current load.

## Operation

- Frame format: one header byte N (the word count), then 4N payload bytes, most-significant byte first. With `IMEM_LOADER_CSUM_EN`, one trailing checksum byte follows.
- States:
  - IDLE: `start` → HDR.
  - HDR: on a transfer, N is latched.
    - N == 0 or N > DEPTH → ERR.
    - Otherwise → DATA, with index=0, byte counter=0 and `word_count`=0.
  - DATA: each transfer shifts the byte into the word register (`word = {word[23:0], rx_data}`) and increments the 2-bit byte counter. The 4th byte → WRITE.
  - WRITE: `imem_we`=1, `imem_addr`=`{index,2'b00}` zero-extended, `imem_wdata`=word. Then index and `word_count` are incremented.
    - If `word_count+1 == N`: → CSUM when the macro is defined, otherwise → DONE.
    - Otherwise → DATA.
  - CSUM: on a transfer, the byte is compared to the running sum. Equal → DONE; not equal → ERR.
  - DONE / ERR: hold. `start` → HDR, which clears `done`/`error` and `word_count`.
- `rx_ready`=1 only in HDR, DATA and CSUM.
- `start` is ignored in HDR, DATA, WRITE and CSUM.
- `cpu_hold`=1 in all states except IDLE and DONE.
- Index wrap-around cannot occur, because N ≤ DEPTH is checked in HDR.
- Bytes presented while `rx_ready`=0 are not consumed; the source must hold them.

## Timing

- Reset values: state IDLE, `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `cpu_hold`=0, `busy`=0, `done`=0, `error`=0, `word_count`=0, internal counters and sum = 0.
- The `start` pulse in cycle t gives `rx_ready`=1 in cycle t+1.
- Write latency: 4th byte accepted in cycle t → `imem_we`=1 in cycle t+1 with `rx_ready`=0 → `rx_ready`=1 again in cycle t+2.
- Best-case throughput is 5 cycles per word.
- `word_count` updates on the edge that ends WRITE.
- DONE is entered on the edge ending the final WRITE (or the CSUM transfer). `done` is registered, so it is high in the following cycle, and `cpu_hold` drops in the same cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `rx_valid` to `rx_ready`.
- Reset asserted mid-load returns to IDLE immediately, with all outputs at their reset values. Memory contents already written are not undone.

## Configuration

- `IMEM_LOADER_CSUM_EN` defined:
  - An 8-bit running sum (mod 256) of all payload bytes is kept and cleared in HDR.
  - After the last WRITE the loader enters CSUM and expects one checksum byte.
  - A mismatch → ERR.
- Not defined:
  - There is no CSUM state and no sum register.
  - The last WRITE → DONE directly.
  - The frame is exactly 1+4N bytes.

## Test plan

- **Two-word load:** `start`, then bytes 02, 20,08,00,20, 20,09,00,27 (plus checksum 0x98 when the macro is enabled). Required response:
  - Writes (addr 0, 0x20080020) then (addr 4, 0x20090027), one `imem_we` cycle each.
  - `done`=1, `word_count`=2, `cpu_hold`=0.
- **Bad header:** N=0x00, and separately N=0x41 with DEPTH=64. Required: `error`=1 on the cycle after the header transfer, no `imem_we`, `cpu_hold`=1.
- **Backpressure and gaps:** `rx_valid` toggled randomly during a 3-word load. Required:
  - Exactly 3 writes with correct data.
  - `rx_ready`=0 in every WRITE cycle.
  - No byte lost or duplicated.
- **Reset mid-load:** assert `reset` after 6 payload bytes. Required: all outputs at reset values immediately. A following `start` plus a full frame loads correctly from address 0.
- **Checksum mismatch** (macro enabled): 1-word frame with a wrong checksum. Required: the word is written, then `error`=1 and `done`=0.
- **Start ignored while busy:** `start` pulsed mid-DATA. Required: no state change, and the load completes normally.
